data_cache_responder: RTL and testbench
=======================================

Name: data_cache_responder

Overview:
- Responder end of the data-cache interface driven by the load/store unit; serves its read and write requests.
- Direct-mapped, write-through, no-write-allocate cache.
- Misses are refilled one line at a time from the memory port.
- Sits between the LS unit and the memory/bus side; returns one response per request with a single-cycle done pulse.

Parameters:
SETS_BITS, 4, log2 of number of lines (16 lines)
WORDS_BITS, 2, log2 of 32-bit words per line (4 words = 128-bit line)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
i_clear  input  1  pipeline flush: invalidate all lines, abort any pending request
i_read  input  1  load request, held until o_done
i_write  input  1  store request, held until o_done; wins over i_read if both are high
i_address  input  32  byte address; word-aligned part used
i_data  input  32  store data
i_wmask  input  4  store byte enables
o_data  output  32  load result, valid while o_done=1
o_done  output  1  one-cycle response pulse
o_mem_read  output  1  line refill request
o_mem_write  output  1  word write-through request
o_mem_address  output  32  line-aligned address for reads, word-aligned address for writes
o_mem_data  output  32  write-through data
o_mem_wmask  output  4  write-through byte enables
i_mem_data  input  32*2^WORDS_BITS  refill line
i_mem_ready  input  1  memory accepted the write / refill data valid

Behaviour:
- Address split: [1:0] byte offset (ignored), [WORDS_BITS+1:2] word, next SETS_BITS index, remainder tag.
- Storage: per line a valid bit, a tag and 2^WORDS_BITS words.
- Reset (async): all valid=0, state IDLE, every output 0.
- FSM states are IDLE, REFILL, WRITE, DONE.
- IDLE, request seen in cycle N:
  - Read hit: o_data registered, DONE in N+1.
  - Read miss: REFILL in N+1.
  - Write (hit or miss): WRITE in N+1.
- REFILL:
  - o_mem_read=1, o_mem_address = {tag,index,0...}.
  - On i_mem_ready at cycle M: line written, valid=1, tag set; requested word latched into o_data; DONE at M+1.
- WRITE:
  - o_mem_write=1 with word address, o_mem_data=i_data, o_mem_wmask=i_wmask.
  - On i_mem_ready at M: if the line hits, the cached word is updated byte-wise per mask in the same edge; DONE at M+1.
  - A write miss does not allocate.
- DONE:
  - o_done=1 for exactly one cycle; requests are ignored in this cycle.
  - Return to IDLE.
  - Requester drops or changes its request after seeing o_done.
- Memory outputs are 0 in every state except REFILL/WRITE.
- o_data holds its last value outside DONE.
- i_clear, highest priority, any state:
  - All valid=0 next edge; state -> IDLE; no o_done for the aborted request.
  - A late i_mem_ready after the abort is ignored.
  - i_clear and a request together in IDLE: the request is ignored.
- Back-to-back requests: the earliest a new request is sampled is the cycle after DONE. A read hit therefore costs 2 cycles per request.
- i_mem_ready outside REFILL/WRITE: ignored.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined:
  - Adds outputs o_hit_count[31:0] and o_miss_count[31:0].
  - Read hits and read misses are counted when the request leaves IDLE.
  - Counters are reset by reset only, not by i_clear, and wrap at 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read 0x0000_1004 with memory returning line {0x44,0x33,0x22,0x11} (word0=0x11) after 3 cycles -> o_mem_read with o_mem_address=0x0000_1000; o_done one cycle after i_mem_ready; o_data=0x22.
- Repeat read 0x0000_1008 -> no memory activity; o_done in 2nd cycle; o_data=0x33.
- Write 0x0000_1004, data 0xAABBCCDD, mask 4'b0011 -> o_mem_write with address 0x0000_1004, mask 0011; then read 0x0000_1004 hits with o_data=0x0000CCDD (prior word 0x22 → upper bytes 0).
- Write miss to 0x0000_2000 then read 0x0000_2000 -> read misses (no allocation) and o_mem_read is asserted.
- Conflict: read 0x0000_1000, then read 0x0000_1000 + (2^(SETS_BITS+WORDS_BITS+2)) = 0x0000_1100 -> second read refills and evicts; third read of 0x0000_1000 misses again.
- i_clear asserted while in REFILL, i_mem_ready the following cycle -> no o_done, state IDLE, and the next read to the same address misses.
- Reset asserted mid-WRITE -> all outputs 0 immediately (async); all lines invalid afterwards.

Source files
------------

// File: rtl/data_cache_responder.sv
// data_cache_responder: direct-mapped write-through no-write-allocate data cache for the LS unit.
// Optional hit/miss counters are compiled in with `define DCACHE_STATS_EN.
module data_cache_responder #(
  parameter int SETS_BITS  = 4,
  parameter int WORDS_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_read,
  input  logic                         i_write,
  input  logic [31:0]                  i_address,
  input  logic [31:0]                  i_data,
  input  logic [3:0]                   i_wmask,
  output logic [31:0]                  o_data,
  output logic                         o_done,
  output logic                         o_mem_read,
  output logic                         o_mem_write,
  output logic [31:0]                  o_mem_address,
  output logic [31:0]                  o_mem_data,
  output logic [3:0]                   o_mem_wmask,
  input  logic [(32<<WORDS_BITS)-1:0]  i_mem_data,
  input  logic                         i_mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                  o_hit_count,
  output logic [31:0]                  o_miss_count
`endif
);
  localparam int SETS   = 1 << SETS_BITS;
  localparam int LINE_W = 32 << WORDS_BITS;
  localparam int TAG_W  = 32 - SETS_BITS - WORDS_BITS - 2;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [LINE_W-1:0]     line_mem [SETS];
  logic [WORDS_BITS-1:0] word;
  logic [SETS_BITS-1:0]  idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic [31:0]           cached;
  logic [31:0]           refill_word;
  logic [31:0]           merged;
  logic                  idle_read;
  logic                  refill_ack;
  logic                  write_ack;
  logic                  unused_addr;
  assign word        = i_address[WORDS_BITS+1:2];
  assign idx         = i_address[SETS_BITS+WORDS_BITS+1:WORDS_BITS+2];
  assign tag         = i_address[31:32-TAG_W];
  assign hit         = valid[idx] && tag_mem[idx] == tag;
  assign cached      = line_mem[idx][{word, 5'b0} +: 32];
  assign refill_word = i_mem_data[{word, 5'b0} +: 32];
  assign unused_addr = ^i_address[1:0];
  assign idle_read   = state == IDLE && !i_clear && !i_write && i_read;
  assign refill_ack  = state == REFILL && !i_clear && i_mem_ready;
  assign write_ack   = state == WRITE && !i_clear && i_mem_ready;
  genvar b;
  generate
    for (b = 0; b < 4; b++) begin : g_merge
      assign merged[b*8 +: 8] = i_wmask[b] ? i_data[b*8 +: 8] : cached[b*8 +: 8];
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // i_clear aborts from any state; the DONE cycle never samples a new request
  always_comb
    state_nx = i_clear         ? IDLE :
               state == IDLE   ? (i_write ? WRITE : i_read ? (hit ? DONE : REFILL) : IDLE) :
               state == DONE   ? IDLE :
               i_mem_ready     ? DONE : state;
  always_comb begin
    o_done        = state == DONE;
    o_mem_read    = state == REFILL;
    o_mem_write   = state == WRITE;
    o_mem_address = o_mem_read  ? {i_address[31:WORDS_BITS+2], {(WORDS_BITS+2){1'b0}}} :
                    o_mem_write ? {i_address[31:2], 2'b00} : '0;
    o_mem_data    = o_mem_write ? i_data  : '0;
    o_mem_wmask   = o_mem_write ? i_wmask : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid  <= '0;
      o_data <= '0;
    end else begin
      if (i_clear)         valid      <= '0;
      else if (refill_ack) valid[idx] <= 1'b1;
      if (idle_read && hit) o_data <= cached;
      else if (refill_ack)  o_data <= refill_word;
    end
  // Line contents need no reset; valid bits gate every use
  always_ff @(posedge clk)
    if (refill_ack) begin
      tag_mem[idx]  <= tag;
      line_mem[idx] <= i_mem_data;
    end else if (write_ack && hit) begin
      line_mem[idx][{word, 5'b0} +: 32] <= merged;
    end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else if (idle_read) begin
      if (hit) o_hit_count  <= o_hit_count + 32'd1;
      else     o_miss_count <= o_miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_data_cache_responder.sv
// tb_data_cache_responder: scoreboard bench for data_cache_responder with a behavioural memory.
module tb_data_cache_responder;
  localparam int SB = 4, WB = 2, LW = 32 << WB;
  logic clk = 0, reset, i_clear, i_read, i_write, i_mem_ready;
  logic [31:0] i_address, i_data, o_data, o_mem_address, o_mem_data;
  logic [3:0] i_wmask, o_mem_wmask;
  logic o_done, o_mem_read, o_mem_write;
  logic [LW-1:0] i_mem_data;
  int checks = 0, failures = 0, hit_exp = 0, miss_exp = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] sb_q [$];
`ifdef DCACHE_STATS_EN
  logic [31:0] o_hit_count, o_miss_count;
`endif
  data_cache_responder #(.SETS_BITS(SB), .WORDS_BITS(WB)) dut (
    .clk(clk), .reset(reset), .i_clear(i_clear), .i_read(i_read), .i_write(i_write),
    .i_address(i_address), .i_data(i_data), .i_wmask(i_wmask), .o_data(o_data), .o_done(o_done),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .o_mem_wmask(o_mem_wmask), .i_mem_data(i_mem_data), .i_mem_ready(i_mem_ready)
`ifdef DCACHE_STATS_EN
    , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hDEAD_0000);
  endfunction
  function automatic logic [LW-1:0] line_of(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int w = 0; w < (1 << WB); w++) l[w*32 +: 32] = mem_rd(la + 32'(w * 4));
    return l;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, d, input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m[k] ? d[k*8 +: 8] : old[k*8 +: 8];
    return r;
  endfunction
  // One transaction: drives the request, plays memory, checks latency, memory port and data
  task automatic req(input bit wr, input logic [31:0] a, d, input logic [3:0] m, input bit exp_mem, input string nm);
    int lat = 0, rdy_it = -1, exp_it;
    bit saw = 0, done = 0;
    logic [31:0] wa, la, exp;
    wa = {a[31:2], 2'b00};
    la = {a[31:WB+2], {(WB+2){1'b0}}};
    i_read = !wr; i_write = wr; i_address = a; i_data = d; i_wmask = m;
    if (!wr) begin
      sb_q.push_back(mem_rd(wa));
      if (exp_mem) miss_exp++; else hit_exp++;
    end
    for (int it = 1; it <= 40 && !done; it++) begin
      @(negedge clk);
      i_mem_ready = 0;
      if (o_done) begin
        done = 1; i_read = 0; i_write = 0;
        exp_it = saw ? rdy_it + 1 : 1;
        checks++;
        if (it != exp_it) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", nm, it, exp_it); end
        if (!wr) begin
          exp = sb_q.pop_front();
          checks++;
          if (o_data !== exp) begin failures++; $display("FAIL %s_data: got %h expected %h", nm, o_data, exp); end
        end
      end else if (o_mem_read || o_mem_write) begin
        if (!saw) begin
          saw = 1;
          checks++;
          if (o_mem_read !== !wr || o_mem_write !== wr || o_mem_address !== (wr ? wa : la)) begin
            failures++;
            $display("FAIL %s_mem_req: got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                     nm, o_mem_read, o_mem_write, o_mem_address, !wr, wr, wr ? wa : la);
          end
          if (wr) begin
            checks++;
            if (o_mem_data !== d || o_mem_wmask !== m) begin
              failures++;
              $display("FAIL %s_wt_data: got %h/%b expected %h/%b", nm, o_mem_data, o_mem_wmask, d, m);
            end
          end
        end
        lat++;
        if (lat == (wr ? 2 : 3)) begin
          i_mem_ready = 1; rdy_it = it;
          if (wr) mem[wa] = merge(mem_rd(wa), d, m);
          else i_mem_data = line_of(la);
        end
      end
    end
    if (!done) begin
      failures++; $display("FAIL %s_timeout: got no o_done expected o_done", nm);
      i_read = 0; i_write = 0;
      if (!wr) void'(sb_q.pop_front());
    end
    checks++;
    if (saw !== exp_mem) begin failures++; $display("FAIL %s_mem_activity: got %b expected %b", nm, saw, exp_mem); end
    @(negedge clk);
    checks++;
    if (o_done !== 0 || o_mem_read !== 0 || o_mem_write !== 0 || o_mem_address !== 0) begin
      failures++;
      $display("FAIL %s_after: got done=%b rd=%b wr=%b addr=%h expected all 0", nm, o_done, o_mem_read, o_mem_write, o_mem_address);
    end
  endtask
  task automatic test_reset;
    reset = 1; i_clear = 0; i_read = 0; i_write = 0; i_address = 0; i_data = 0; i_wmask = 0;
    i_mem_ready = 0; i_mem_data = '0;
    #1;
    checks++;
    if ({o_data, o_done, o_mem_read, o_mem_write, o_mem_address, o_mem_data, o_mem_wmask} !== '0) begin
      failures++; $display("FAIL reset_outputs: got data=%h done=%b addr=%h expected 0", o_data, o_done, o_mem_address);
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_read_miss;
    mem[32'h1000] = 32'h11; mem[32'h1004] = 32'h22; mem[32'h1008] = 32'h33; mem[32'h100C] = 32'h44;
    req(0, 32'h1004, 0, 0, 1, "cold_read");
    checks++;
    if (o_data !== 32'h22) begin failures++; $display("FAIL cold_read_const: got %h expected %h", o_data, 32'h22); end
  endtask
  task automatic test_read_hit;
    req(0, 32'h1008, 0, 0, 0, "hit_read");
    checks++;
    if (o_data !== 32'h33) begin failures++; $display("FAIL hit_read_const: got %h expected %h", o_data, 32'h33); end
  endtask
  task automatic test_write_hit;
    req(1, 32'h1004, 32'hAABBCCDD, 4'b0011, 1, "write_hit");
    req(0, 32'h1004, 0, 0, 0, "read_after_write");
    checks++;
    if (o_data !== 32'h0000CCDD) begin failures++; $display("FAIL write_merge_const: got %h expected %h", o_data, 32'h0000CCDD); end
  endtask
  task automatic test_write_miss;
    req(1, 32'h2000, 32'h12345678, 4'b1111, 1, "write_miss");
    req(0, 32'h2000, 0, 0, 1, "read_after_write_miss");
  endtask
  task automatic test_conflict;
    req(0, 32'h1000, 0, 0, 1, "conflict_first");
    req(0, 32'h100C, 0, 0, 0, "conflict_hit");
    req(0, 32'h1100, 0, 0, 1, "conflict_evict");
    req(0, 32'h1000, 0, 0, 1, "conflict_again");
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp;
    sb_q.push_back(mem_rd(32'h1004)); hit_exp++;
    i_read = 1; i_address = 32'h1004;
    @(negedge clk);
    exp = sb_q.pop_front();
    checks++;
    if (o_done !== 1 || o_data !== exp) begin failures++; $display("FAIL b2b_first: got done=%b data=%h expected 1/%h", o_done, o_data, exp); end
    i_address = 32'h1008; sb_q.push_back(mem_rd(32'h1008)); hit_exp++;
    @(negedge clk);
    checks++;
    if (o_done !== 0) begin failures++; $display("FAIL b2b_gap: got done=%b expected 0", o_done); end
    @(negedge clk);
    exp = sb_q.pop_front();
    i_read = 0;
    checks++;
    if (o_done !== 1 || o_data !== exp) begin failures++; $display("FAIL b2b_second: got done=%b data=%h expected 1/%h", o_done, o_data, exp); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_write;
    bit seen = 0;
    i_write = 1; i_address = 32'h1000; i_data = 32'hFFFF_0000; i_wmask = 4'hF;
    for (int it = 0; it < 10 && !seen; it++) begin
      @(negedge clk);
      seen = o_mem_write;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midwrite_start: got no o_mem_write expected o_mem_write"); end
    #2 reset = 1;
    #1;
    checks++;
    if ({o_data, o_done, o_mem_read, o_mem_write, o_mem_address, o_mem_data, o_mem_wmask} !== '0) begin
      failures++; $display("FAIL midwrite_reset: got wr=%b addr=%h data=%h expected 0", o_mem_write, o_mem_address, o_mem_data);
    end
    i_write = 0;
    @(negedge clk);
    reset = 0; hit_exp = 0; miss_exp = 0;
    req(0, 32'h1000, 0, 0, 1, "after_reset");
  endtask
  task automatic test_clear;
    bit seen = 0;
    i_read = 1; i_address = 32'h3000; miss_exp++;
    for (int it = 0; it < 10 && !seen; it++) begin
      @(negedge clk);
      seen = o_mem_read;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL clear_refill_start: got no o_mem_read expected o_mem_read"); end
    i_clear = 1; i_read = 0;
    @(negedge clk);
    i_clear = 0; i_mem_ready = 1; i_mem_data = line_of(32'h3000);
    checks++;
    if (o_done !== 0 || o_mem_read !== 0) begin failures++; $display("FAIL clear_abort: got done=%b rd=%b expected 0/0", o_done, o_mem_read); end
    @(negedge clk);
    i_mem_ready = 0;
    repeat (2) begin
      checks++;
      if (o_done !== 0) begin failures++; $display("FAIL clear_late_ready: got done=%b expected 0", o_done); end
      @(negedge clk);
    end
    req(0, 32'h3000, 0, 0, 1, "clear_reread");
    req(0, 32'h1000, 0, 0, 1, "clear_invalidated");
    i_read = 1; i_address = 32'h1000; i_clear = 1;
    @(negedge clk);
    i_read = 0; i_clear = 0;
    checks++;
    if (o_done !== 0 || o_mem_read !== 0) begin failures++; $display("FAIL clear_with_req: got done=%b rd=%b expected 0/0", o_done, o_mem_read); end
    @(negedge clk);
    req(0, 32'h1000, 0, 0, 1, "clear_idle_invalidated");
  endtask
  initial begin
    test_reset;
    test_read_miss;
    test_read_hit;
    test_write_hit;
    test_write_miss;
    test_conflict;
    test_back_to_back;
    test_reset_mid_write;
    test_clear;
`ifdef DCACHE_STATS_EN
    checks++;
    if (o_hit_count !== 32'(hit_exp) || o_miss_count !== 32'(miss_exp)) begin
      failures++; $display("FAIL stats: got %0d/%0d expected %0d/%0d", o_hit_count, o_miss_count, hit_exp, miss_exp);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
